// File: rtl/fibo_pkg.sv
// Shared types for the Fibonacci term engine.
// FSM state encoding and datapath opcodes.
package fibo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    EMIT,
    CALC,
    DONE
  } state_e;

  typedef enum logic {
    ALU_NOP,
    ALU_ADD
  } alu_op_e;

endpackage

// File: rtl/fibo_if.sv
// Run-request and term-stream bundle for fibo_engine.
// master = requester/consumer, slave = engine.
interface fibo_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);

  logic             start;
  logic [CNT_W-1:0] n_in;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic             busy;
  logic [WIDTH-1:0] term;
  logic [CNT_W-1:0] term_idx;
  logic             term_valid;
  logic             term_ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero_flag;

  modport master (
    output start, n_in, seed0, seed1, term_ready,
    input  busy, term, term_idx, term_valid,
    input  done, result, overflow, zero_flag
  );

  modport slave (
    input  start, n_in, seed0, seed1, term_ready,
    output busy, term, term_idx, term_valid,
    output done, result, overflow, zero_flag
  );

endinterface

// File: rtl/fibo_regfile.sv
// DEPTH x WIDTH term store: two async reads,
// one sync write, sync clear on reset.
module fibo_regfile #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrt_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/fibo_engine.sv
// Streams F(0)..F(n) from two seeds through a
// small circular register file, one term per handshake.
module fibo_engine
  import fibo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  fibo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W:0] TWO = 2;

  state_e           state;
  state_e           state_nx;
  alu_op_e          alu_op;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] seed0_q;
  logic [WIDTH-1:0] seed1_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    wr_addr;
  logic             wrt_en;
  logic [WIDTH:0]   sum;
  logic             hs;
  logic             last;
  logic             calc_wr;

  assign hs      = (state == EMIT) && bus.term_ready;
  assign last    = (idx == n_q);
  // Slots for idx+2 beyond n are never read, so skip the write.
  assign calc_wr = ({1'b0, idx} + TWO) <= {1'b0, n_q};

  fibo_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wrt_en   (wrt_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(AW'(idx)),
    .rd_addr_b(AW'(idx) + AW'(1)),
    .rd_data_a(rd_a),
    .rd_data_b(rd_b)
  );

  always_comb begin
    alu_op = ALU_NOP;
    if (state == CALC && calc_wr) begin
      alu_op = ALU_ADD;
    end
    sum = {1'b0, rd_a};
    if (alu_op == ALU_ADD) begin
      sum = {1'b0, rd_a} + {1'b0, rd_b};
    end
  end

  always_comb begin
    wrt_en  = 1'b0;
    wr_addr = '0;
    wr_data = sum[WIDTH-1:0];
    unique case (1'b1)
      state == LOAD0: begin
        wrt_en  = 1'b1;
        wr_data = seed0_q;
      end
      state == LOAD1: begin
        wrt_en  = 1'b1;
        wr_addr = AW'(1);
        wr_data = seed1_q;
      end
      alu_op == ALU_ADD: begin
        wrt_en  = 1'b1;
        wr_addr = AW'(idx) + AW'(2);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = LOAD0;
      LOAD0: state_nx = LOAD1;
      LOAD1: state_nx = EMIT;
      EMIT:  if (bus.term_ready) state_nx = last ? DONE : CALC;
      CALC:  state_nx = EMIT;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      n_q      <= '0;
      seed0_q  <= '0;
      seed1_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        n_q     <= bus.n_in;
        seed0_q <= bus.seed0;
        seed1_q <= bus.seed1;
        idx     <= '0;
        ovf_q   <= 1'b0;
      end
      if (alu_op == ALU_ADD && sum[WIDTH]) begin
        ovf_q <= 1'b1;
      end
      if (state == CALC) begin
        idx <= idx + 1'b1;
      end
      if (hs) begin
        result_q <= rd_a;
        zero_q   <= (rd_a == '0);
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.term       = rd_a;
  assign bus.term_idx   = idx;
  assign bus.term_valid = (state == EMIT);
  assign bus.done       = (state == DONE);
  assign bus.result     = result_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero_flag  = zero_q;

endmodule

// File: tb/tb_fibo_engine.sv
// Bench for fibo_engine: WIDTH=4 and WIDTH=8 instances
// checked against a plain-arithmetic Fibonacci model.
module tb_fibo_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       term_ready;
  logic       sel;
  logic [3:0] n_in;
  logic [7:0] seed0;
  logic [7:0] seed1;

  always #5 clk = ~clk;

  fibo_if #(.WIDTH(4), .CNT_W(4)) bus4 ();
  fibo_if #(.WIDTH(8), .CNT_W(4)) bus8 ();

  fibo_engine #(.WIDTH(4), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  fibo_engine #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  assign bus4.start      = start & ~sel;
  assign bus4.n_in       = n_in;
  assign bus4.seed0      = seed0[3:0];
  assign bus4.seed1      = seed1[3:0];
  assign bus4.term_ready = term_ready;
  assign bus8.start      = start & sel;
  assign bus8.n_in       = n_in;
  assign bus8.seed0      = seed0;
  assign bus8.seed1      = seed1;
  assign bus8.term_ready = term_ready;

  logic       g_valid;
  logic       g_busy;
  logic       g_done;
  logic       g_ovf;
  logic       g_zero;
  logic [7:0] g_term;
  logic [7:0] g_res;
  logic [3:0] g_idx;

  assign g_valid = sel ? bus8.term_valid : bus4.term_valid;
  assign g_busy  = sel ? bus8.busy : bus4.busy;
  assign g_done  = sel ? bus8.done : bus4.done;
  assign g_ovf   = sel ? bus8.overflow : bus4.overflow;
  assign g_zero  = sel ? bus8.zero_flag : bus4.zero_flag;
  assign g_term  = sel ? bus8.term : {4'b0, bus4.term};
  assign g_res   = sel ? bus8.result : {4'b0, bus4.result};
  assign g_idx   = sel ? bus8.term_idx : bus4.term_idx;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int mdl_term[16];
  bit mdl_ovf;

  function automatic void model(input int n, input int s0, input int s1, input int w);
    int m;
    int s;
    m = 1 << w;
    mdl_ovf = 1'b0;
    mdl_term[0] = s0 % m;
    mdl_term[1] = s1 % m;
    for (int i = 2; i <= n; i++) begin
      s = mdl_term[i-2] + mdl_term[i-1];
      if (s >= m) mdl_ovf = 1'b1;
      mdl_term[i] = s % m;
    end
  endfunction

  // mode 0: ready high, 1: random ready, 2: 3-cycle stall at idx 2
  task automatic run(input int n, input int s0, input int s1,
                     input int mode, input bit poke);
    int w;
    int k;
    int cyc;
    int last_hs;
    int stalls;
    int pt;
    int pi;
    bit pv;
    bit pr;
    bit seen_v;
    bit fin;
    w = sel ? 8 : 4;
    model(n, s0, s1, w);
    @(negedge clk);
    start = 1'b1;
    n_in = 4'(n);
    seed0 = 8'(s0);
    seed1 = 8'(s1);
    term_ready = 1'b1;
    k = 0;
    cyc = 0;
    last_hs = -100;
    stalls = 0;
    pv = 1'b0;
    pr = 1'b1;
    pt = 0;
    pi = 0;
    seen_v = 1'b0;
    fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 5) begin
        start = 1'b1;
        n_in = 4'd2;
        seed0 = 8'd9;
        seed1 = 8'd9;
      end
      if (pv && !pr) begin
        check("hold_valid", int'(g_valid), 1);
        check("hold_term", int'(g_term), pt);
        check("hold_idx", int'(g_idx), pi);
      end
      case (mode)
        1: term_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (g_valid && g_idx == 4'd2 && stalls < 3) begin
            term_ready = 1'b0;
            stalls++;
          end else begin
            term_ready = 1'b1;
          end
        end
        default: term_ready = 1'b1;
      endcase
      if (g_valid && !seen_v) begin
        seen_v = 1'b1;
        check("first_valid_latency", cyc, 3);
      end
      if (g_valid && term_ready) begin
        if (k <= n) begin
          check("term", int'(g_term), mdl_term[k]);
          check("term_idx", int'(g_idx), k);
        end else begin
          check("extra_term", k, n);
        end
        if (mode == 0 && k > 0) check("term_gap", cyc - last_hs, 2);
        last_hs = cyc;
        k++;
      end
      if (g_done) begin
        check("done_slot", cyc, last_hs + 1);
        check("done_terms", k, n + 1);
        check("busy_in_done", int'(g_busy), 1);
        fin = 1'b1;
      end
    end
    if (!fin) check("run_timeout", 0, 1);
    check("result", int'(g_res), mdl_term[n]);
    check("overflow", int'(g_ovf), int'(mdl_ovf));
    check("zero_flag", int'(g_zero), int'(mdl_term[n] == 0));
    @(negedge clk);
    check("done_single", int'(g_done), 0);
    check("busy_after", int'(g_busy), 0);
  endtask

  typedef struct {
    int n;
    int s0;
    int s1;
    int mode;
    int poke;
    int w8;
    int exp_res;
    int exp_ovf;
  } vec_t;

  vec_t vecs[8];
  bit   found;

  initial begin
    vecs = '{
      '{6,  0, 1, 0, 0, 0,  8, 0},
      '{8,  0, 1, 0, 0, 0,  5, 1},
      '{0,  0, 7, 0, 0, 0,  0, 0},
      '{5,  0, 1, 2, 0, 0,  5, 0},
      '{6,  0, 1, 0, 1, 0,  8, 0},
      '{1,  3, 4, 0, 0, 0,  4, 0},
      '{15, 1, 1, 1, 0, 0, 11, 1},
      '{10, 1, 1, 0, 0, 1, 89, 0}
    };
    start = 1'b0;
    term_ready = 1'b0;
    sel = 1'b0;
    n_in = '0;
    seed0 = '0;
    seed1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_busy", int'(g_busy), 0);
      check("rst_valid", int'(g_valid), 0);
      check("rst_done", int'(g_done), 0);
      check("rst_result", int'(g_res), 0);
      check("rst_ovf", int'(g_ovf), 0);
      check("rst_zero", int'(g_zero), 1);
      check("rst_term", int'(g_term), 0);
      check("rst_idx", int'(g_idx), 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].w8[0];
      run(vecs[i].n, vecs[i].s0, vecs[i].s1, vecs[i].mode, vecs[i].poke[0]);
      check("vec_result", int'(g_res), vecs[i].exp_res);
      check("vec_overflow", int'(g_ovf), vecs[i].exp_ovf);
    end

    // Reset in the middle of a handshake at idx 3.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n_in = 4'd6;
    seed0 = 8'd9;
    seed1 = 8'd9;
    term_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (g_valid && g_idx == 4'd3) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_idx3", int'(found), 1);
    check("term_idx3", int'(g_term), 11);
    check("ovf_before_rst", int'(g_ovf), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(g_busy), 0);
    check("midrst_valid", int'(g_valid), 0);
    check("midrst_done", int'(g_done), 0);
    check("midrst_result", int'(g_res), 0);
    check("midrst_ovf", int'(g_ovf), 0);
    check("midrst_zero", int'(g_zero), 1);
    check("midrst_term", int'(g_term), 0);
    check("midrst_idx", int'(g_idx), 0);

    for (int i = 0; i < 24; i++) begin
      int w;
      sel = $urandom_range(0, 1) != 0;
      w = sel ? 8 : 4;
      run($urandom_range(0, 15),
          $urandom_range(0, (1 << w) - 1),
          $urandom_range(0, (1 << w) - 1),
          1, $urandom_range(0, 1) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
